// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter. Two writeback sources (A: ALU/EX, B: memory)
// share one registered write port. Round-robin priority on conflicts, with a
// one-entry pending slot that holds the conflict loser for one cycle. Writes to
// the hardwired-zero register are accepted and silently dropped.
module regfile_wr_arbiter #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 64,
  parameter int NUM_REGS = 32,
  parameter int ZERO_REG = 31
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                a_valid,
  input  logic [ADDR_W-1:0]   a_addr,
  input  logic [DATA_W-1:0]   a_data,
  output logic                a_ready,
  input  logic                b_valid,
  input  logic [ADDR_W-1:0]   b_addr,
  input  logic [DATA_W-1:0]   b_data,
  output logic                b_ready,
  output logic                wr_en,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [DATA_W-1:0]   wr_data,
  output logic [NUM_REGS-1:0] wr_dec,
  output logic                pend_full
);

  // Which source wins the next two-way conflict.
  typedef enum logic {PRI_A = 1'b0, PRI_B = 1'b1} pri_e;

  pri_e                ptr_q, ptr_d;
  logic                pend_full_q, pend_full_d;
  logic [ADDR_W-1:0]   pend_addr_q, pend_addr_d;
  logic [DATA_W-1:0]   pend_data_q, pend_data_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic [NUM_REGS-1:0] wr_dec_q, wr_dec_d;

  logic a_live, b_live;

  // Readies only depend on slot occupancy and are held low during reset.
  assign a_ready = ~pend_full_q & ~reset;
  assign b_ready = ~pend_full_q & ~reset;

  // A request is live when it handshakes and targets a writable register.
  assign a_live = a_valid & a_ready & (a_addr != ADDR_W'(ZERO_REG));
  assign b_live = b_valid & b_ready & (b_addr != ADDR_W'(ZERO_REG));

  // Select the next output-register contents, pending entry and pointer.
  always_comb begin
    ptr_d       = ptr_q;
    pend_full_d = 1'b0;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    if (pend_full_q) begin
      // Drain the parked loser; readies are low so nothing new is live.
      wr_en_d   = 1'b1;
      wr_addr_d = pend_addr_q;
      wr_data_d = pend_data_q;
    end else if (a_live && b_live) begin
      wr_en_d     = 1'b1;
      pend_full_d = 1'b1;
      if (ptr_q == PRI_A) begin
        wr_addr_d   = a_addr;
        wr_data_d   = a_data;
        pend_addr_d = b_addr;
        pend_data_d = b_data;
        ptr_d       = PRI_B;
      end else begin
        wr_addr_d   = b_addr;
        wr_data_d   = b_data;
        pend_addr_d = a_addr;
        pend_data_d = a_data;
        ptr_d       = PRI_A;
      end
    end else if (a_live) begin
      wr_en_d   = 1'b1;
      wr_addr_d = a_addr;
      wr_data_d = a_data;
    end else if (b_live) begin
      wr_en_d   = 1'b1;
      wr_addr_d = b_addr;
      wr_data_d = b_data;
    end
    // Decoded enable is precomputed so the register-file sees it from a flop.
    wr_dec_d = wr_en_d ? (NUM_REGS'(1) << wr_addr_d) : '0;
  end

  // Control and write-port registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q       <= PRI_A;
      pend_full_q <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_dec_q    <= '0;
    end else begin
      ptr_q       <= ptr_d;
      pend_full_q <= pend_full_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      wr_dec_q    <= wr_dec_d;
    end
  end

  // Pending payload; only meaningful while pend_full_q is set, so no reset.
  always_ff @(posedge clk) begin
    pend_addr_q <= pend_addr_d;
    pend_data_q <= pend_data_d;
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign wr_dec    = wr_dec_q;
  assign pend_full = pend_full_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: reset, single writes, conflicts,
// round-robin alternation, zero-register drops, same-address ordering and
// asynchronous reset while an entry is pending.
module tb_regfile_wr_arbiter;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 64;
  localparam int NUM_REGS = 32;
  localparam int ZERO_REG = 31;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                a_valid, b_valid;
  logic [ADDR_W-1:0]   a_addr, b_addr;
  logic [DATA_W-1:0]   a_data, b_data;
  logic                a_ready, b_ready;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic [NUM_REGS-1:0] wr_dec;
  logic                pend_full;

  int total = 0;
  int bad   = 0;

  regfile_wr_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ZERO_REG(ZERO_REG)
  ) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_dec(wr_dec),
    .pend_full(pend_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic av, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
                       input logic bv, input logic [ADDR_W-1:0] ba, input logic [DATA_W-1:0] bd);
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  // Expect a write of addr/data this cycle with its one-hot enable.
  task automatic exp_wr(input string tag, input logic [ADDR_W-1:0] ad, input logic [DATA_W-1:0] dt);
    logic [NUM_REGS-1:0] onehot;
    onehot = '0;
    onehot[ad] = 1'b1;
    chk({tag, "_en"},   64'(wr_en),   64'd1);
    chk({tag, "_addr"}, 64'(wr_addr), 64'(ad));
    chk({tag, "_data"}, wr_data,      dt);
    chk({tag, "_dec"},  64'(wr_dec),  64'(onehot));
  endtask

  task automatic exp_idle(input string tag);
    chk({tag, "_en"},  64'(wr_en),  64'd0);
    chk({tag, "_dec"}, 64'(wr_dec), 64'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    idle();
    // Reset state
    tick();
    tick();
    chk("rst_en",   64'(wr_en),     64'd0);
    chk("rst_addr", 64'(wr_addr),   64'd0);
    chk("rst_data", wr_data,        64'd0);
    chk("rst_dec",  64'(wr_dec),    64'd0);
    chk("rst_pend", 64'(pend_full), 64'd0);
    chk("rst_ardy", 64'(a_ready),   64'd0);
    chk("rst_brdy", 64'(b_ready),   64'd0);
    reset = 1'b0;
    tick();
    chk("post_rst_ardy", 64'(a_ready), 64'd1);
    chk("post_rst_brdy", 64'(b_ready), 64'd1);
    exp_idle("post_rst");

    // Single A write
    drive(1'b1, 5'd3, 64'h11, 1'b0, '0, '0);
    chk("t1_ardy", 64'(a_ready), 64'd1);
    tick();
    idle();
    exp_wr("t1_wr", 5'd3, 64'h11);
    chk("t1_dec_const", 64'(wr_dec), 64'h0000_0008);
    chk("t1_pend", 64'(pend_full), 64'd0);
    tick();
    exp_idle("t1_idle");
    chk("t1_addr_hold", 64'(wr_addr), 64'd3);
    chk("t1_data_hold", wr_data, 64'h11);

    // First conflict: A wins, B parked one cycle
    drive(1'b1, 5'd4, 64'hAA, 1'b1, 5'd5, 64'hBB);
    tick();
    idle();
    exp_wr("t2_n1", 5'd4, 64'hAA);
    chk("t2_n1_pend", 64'(pend_full), 64'd1);
    chk("t2_n1_ardy", 64'(a_ready),   64'd0);
    chk("t2_n1_brdy", 64'(b_ready),   64'd0);
    tick();
    exp_wr("t2_n2", 5'd5, 64'hBB);
    chk("t2_n2_pend", 64'(pend_full), 64'd0);
    chk("t2_n2_ardy", 64'(a_ready),   64'd1);
    chk("t2_n2_brdy", 64'(b_ready),   64'd1);
    tick();
    exp_idle("t2_n3");

    // Same address on first conflict after reset: A's data then B's
    do_reset();
    drive(1'b1, 5'd6, 64'h1, 1'b1, 5'd6, 64'h2);
    tick();
    idle();
    exp_wr("t5_first", 5'd6, 64'h1);
    tick();
    exp_wr("t5_second", 5'd6, 64'h2);
    tick();
    exp_idle("t5_idle");

    // Continuous conflict: A=1,2,3 and B=9,10,11 held valid until accepted
    do_reset();
    drive(1'b1, 5'd1, 64'h101, 1'b1, 5'd9, 64'h109);
    tick();
    exp_wr("t3_c1", 5'd1, 64'h101);
    drive(1'b1, 5'd2, 64'h102, 1'b1, 5'd10, 64'h10A);
    tick();
    exp_wr("t3_c2", 5'd9, 64'h109);
    tick();
    exp_wr("t3_c3", 5'd10, 64'h10A);
    drive(1'b1, 5'd3, 64'h103, 1'b1, 5'd11, 64'h10B);
    tick();
    exp_wr("t3_c4", 5'd2, 64'h102);
    tick();
    exp_wr("t3_c5", 5'd3, 64'h103);
    idle();
    tick();
    exp_wr("t3_c6", 5'd11, 64'h10B);
    tick();
    exp_idle("t3_end");

    // Zero-register writes are accepted and dropped
    drive(1'b1, 5'd31, 64'hDEAD, 1'b0, '0, '0);
    chk("t4_ardy", 64'(a_ready), 64'd1);
    tick();
    idle();
    exp_idle("t4_zero");
    chk("t4_zero_pend", 64'(pend_full), 64'd0);
    drive(1'b1, 5'd31, 64'hBEEF, 1'b1, 5'd7, 64'h77);
    tick();
    idle();
    exp_wr("t4_b7", 5'd7, 64'h77);
    chk("t4_b7_pend", 64'(pend_full), 64'd0);
    tick();
    exp_idle("t4_idle");
    // Pointer still favours B after the three-conflict stream
    drive(1'b1, 5'd12, 64'hC12, 1'b1, 5'd13, 64'hC13);
    tick();
    idle();
    exp_wr("t4_ptr_first", 5'd13, 64'hC13);
    tick();
    exp_wr("t4_ptr_second", 5'd12, 64'hC12);
    tick();
    exp_idle("t4_end");

    // Async reset while the loser is pending
    drive(1'b1, 5'd20, 64'h20, 1'b1, 5'd21, 64'h21);
    tick();
    idle();
    exp_wr("t6_n1", 5'd20, 64'h20);
    chk("t6_n1_pend", 64'(pend_full), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_rst_en",   64'(wr_en),     64'd0);
    chk("t6_rst_dec",  64'(wr_dec),    64'd0);
    chk("t6_rst_pend", 64'(pend_full), 64'd0);
    chk("t6_rst_ardy", 64'(a_ready),   64'd0);
    tick();
    reset = 1'b0;
    tick();
    exp_idle("t6_no_pending");
    drive(1'b1, 5'd22, 64'h22, 1'b1, 5'd23, 64'h23);
    tick();
    idle();
    exp_wr("t6_a_wins", 5'd22, 64'h22);
    tick();
    exp_wr("t6_b_next", 5'd23, 64'h23);
    tick();
    exp_idle("t6_end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
